// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline hazard control unit.
// Holds the FSM encoding, the scoreboard entry layout and the parameter defaults.
package hazard_ctrl_unit_pkg;

    localparam int REG_BIT          = 5;
    localparam int SCB_ENTRY_BIT    = 7;
    localparam int FSM_STATE_BIT    = 2;
    localparam int STALL_CNT_BIT    = 32;
    localparam int SCB_DEPTH_DEF    = 3;
    localparam int DRAIN_CYCLES_DEF = 3;

    typedef enum logic [FSM_STATE_BIT-1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } hcu_state_e;

    typedef struct packed {
        logic               valid;
        logic [REG_BIT-1:0] rw;
        logic               memtoreg;
    } scb_entry_t;

    // Register $0 is hard-wired, so it never creates a dependency.
    function automatic logic src_match(input logic src_used, input scb_entry_t ent,
                                       input logic [REG_BIT-1:0] req);
        return src_used && ent.valid && (ent.rw == req) && (req != {REG_BIT{1'b0}});
    endfunction

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Bundle of ID-stage request, EX-stage events and the control/forwarding outputs.
// The master side drives the pipeline inputs; the hazard unit is the slave.
interface hazard_ctrl_unit_if;
    import hazard_ctrl_unit_pkg::*;

    logic [REG_BIT-1:0]       id_req_a;
    logic [REG_BIT-1:0]       id_req_b;
    logic                     id_use_a;
    logic                     id_use_b;
    logic [REG_BIT-1:0]       id_req_w;
    logic                     id_w_en;
    logic                     id_memtoreg;
    logic                     jp_success;
    logic                     halt_req;
    logic                     load_use;
    logic                     en_pc;
    logic                     en_if_id;
    logic                     en_id_ex;
    logic                     flush_if_id;
    logic                     redirect_regA_ex_dm;
    logic                     redirect_regA_dm_wb;
    logic                     redirect_regB_ex_dm;
    logic                     redirect_regB_dm_wb;
    logic                     halted;
    logic [STALL_CNT_BIT-1:0] stall_cnt;

    modport master (
        output id_req_a, id_req_b, id_use_a, id_use_b, id_req_w, id_w_en, id_memtoreg,
               jp_success, halt_req,
        input  load_use, en_pc, en_if_id, en_id_ex, flush_if_id,
               redirect_regA_ex_dm, redirect_regA_dm_wb, redirect_regB_ex_dm,
               redirect_regB_dm_wb, halted, stall_cnt
    );

    modport slave (
        input  id_req_a, id_req_b, id_use_a, id_use_b, id_req_w, id_w_en, id_memtoreg,
               jp_success, halt_req,
        output load_use, en_pc, en_if_id, en_id_ex, flush_if_id,
               redirect_regA_ex_dm, redirect_regA_dm_wb, redirect_regB_ex_dm,
               redirect_regB_dm_wb, halted, stall_cnt
    );

endinterface

// File: rtl/hazard_ctrl_unit_scoreboard.sv
// In-flight destination tracker (EX, DM, WB) with source-operand match compare.
// Entry 0 is the instruction now in EX; the oldest entry only ages out.
module hcu_scoreboard
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int DEPTH = SCB_DEPTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               shift_en,
    input  logic               bubble,
    input  logic               id_w_en,
    input  logic [REG_BIT-1:0] id_req_w,
    input  logic               id_memtoreg,
    input  logic               id_use_a,
    input  logic [REG_BIT-1:0] id_req_a,
    input  logic               id_use_b,
    input  logic [REG_BIT-1:0] id_req_b,
    output logic               match_a0,
    output logic               match_a1,
    output logic               match_b0,
    output logic               match_b1,
    output logic               ex_memtoreg
);

    scb_entry_t ent_r [DEPTH];
    scb_entry_t new_ent_s;

    // Build the entry that the ID instruction will occupy once it reaches EX.
    always_comb begin
        new_ent_s = {SCB_ENTRY_BIT{1'b0}};
        if (bubble) begin
            new_ent_s = {SCB_ENTRY_BIT{1'b0}};
        end else begin
            new_ent_s.valid    = id_w_en && (id_req_w != {REG_BIT{1'b0}});
            new_ent_s.rw       = id_req_w;
            new_ent_s.memtoreg = id_memtoreg;
        end
    end

    // Shift register advancing one stage per enabled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= {SCB_ENTRY_BIT{1'b0}};
            end
        end else if (shift_en) begin
            ent_r[0] <= new_ent_s;
            for (int i = 1; i < DEPTH; i++) begin
                ent_r[i] <= ent_r[i-1];
            end
        end
    end

    assign match_a0    = src_match(id_use_a, ent_r[0], id_req_a);
    assign match_a1    = src_match(id_use_a, ent_r[1], id_req_a);
    assign match_b0    = src_match(id_use_b, ent_r[0], id_req_b);
    assign match_b1    = src_match(id_use_b, ent_r[1], id_req_b);
    assign ex_memtoreg = ent_r[0].memtoreg;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard control: load-use stall, forwarding selects, jump squash and halt drain.
// Halt handling dominates jumps, which dominate load-use stalls.
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int SCB_DEPTH    = SCB_DEPTH_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_ctrl_unit_if.slave  bus
);

    localparam int                DCNT_BIT  = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DCNT_BIT-1:0] DCNT_LAST = DCNT_BIT'(DRAIN_CYCLES - 1);

    hcu_state_e               state_r;
    logic [DCNT_BIT-1:0]      drain_cnt_r;
    logic [STALL_CNT_BIT-1:0] stall_cnt_r;
    logic                     halted_r;

    logic match_a0_s, match_a1_s, match_b0_s, match_b1_s, ex_memtoreg_s;
    logic shift_en_s, bubble_s, load_use_s;
    logic en_pc_s, en_if_id_s, en_id_ex_s, flush_s;
    logic a_ex_dm_s, a_dm_wb_s, b_ex_dm_s, b_dm_wb_s;

    hcu_scoreboard #(
        .DEPTH (SCB_DEPTH)
    ) u_scb (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift_en    (shift_en_s),
        .bubble      (bubble_s),
        .id_w_en     (bus.id_w_en),
        .id_req_w    (bus.id_req_w),
        .id_memtoreg (bus.id_memtoreg),
        .id_use_a    (bus.id_use_a),
        .id_req_a    (bus.id_req_a),
        .id_use_b    (bus.id_use_b),
        .id_req_b    (bus.id_req_b),
        .match_a0    (match_a0_s),
        .match_a1    (match_a1_s),
        .match_b0    (match_b0_s),
        .match_b1    (match_b1_s),
        .ex_memtoreg (ex_memtoreg_s)
    );

    // Stage enables, squash and forwarding selects from state and hazard priority.
    always_comb begin
        shift_en_s = 1'b1;
        bubble_s   = 1'b0;
        load_use_s = 1'b0;
        en_pc_s    = 1'b1;
        en_if_id_s = 1'b1;
        en_id_ex_s = 1'b1;
        flush_s    = 1'b0;
        a_ex_dm_s  = 1'b0;
        a_dm_wb_s  = 1'b0;
        b_ex_dm_s  = 1'b0;
        b_dm_wb_s  = 1'b0;
        if (rst_n) begin
            case (state_r)
                ST_RUN: begin
                    a_ex_dm_s = match_a0_s && !ex_memtoreg_s;
                    a_dm_wb_s = match_a1_s && !a_ex_dm_s;
                    b_ex_dm_s = match_b0_s && !ex_memtoreg_s;
                    b_dm_wb_s = match_b1_s && !b_ex_dm_s;
                    if (bus.halt_req) begin
                        bubble_s = 1'b0;
                    end else if (bus.jp_success) begin
                        flush_s  = 1'b1;
                        bubble_s = 1'b1;
                    end else if ((match_a0_s || match_b0_s) && ex_memtoreg_s) begin
                        load_use_s = 1'b1;
                        en_pc_s    = 1'b0;
                        en_if_id_s = 1'b0;
                        bubble_s   = 1'b1;
                    end else begin
                        bubble_s = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    en_pc_s    = 1'b0;
                    en_if_id_s = 1'b0;
                    flush_s    = 1'b1;
                    bubble_s   = 1'b1;
                end
                ST_HALTED: begin
                    shift_en_s = 1'b0;
                    en_pc_s    = 1'b0;
                    en_if_id_s = 1'b0;
                    en_id_ex_s = 1'b0;
                end
                default: begin
                    shift_en_s = 1'b0;
                    en_pc_s    = 1'b0;
                    en_if_id_s = 1'b0;
                    en_id_ex_s = 1'b0;
                end
            endcase
        end else begin
            shift_en_s = 1'b0;
        end
    end

    // Run/drain/halt sequencing plus the saturating stall statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= {DCNT_BIT{1'b0}};
            stall_cnt_r <= {STALL_CNT_BIT{1'b0}};
            halted_r    <= 1'b0;
        end else begin
            if (load_use_s && (stall_cnt_r != {STALL_CNT_BIT{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + 32'd1;
            end
            case (state_r)
                ST_RUN: begin
                    if (bus.halt_req) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= {DCNT_BIT{1'b0}};
                    end
                end
                ST_DRAIN: begin
                    drain_cnt_r <= drain_cnt_r + DCNT_BIT'(1);
                    if (drain_cnt_r == DCNT_LAST) begin
                        state_r  <= ST_HALTED;
                        halted_r <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                // An illegal encoding parks the pipeline rather than running blind.
                default: begin
                    state_r  <= ST_HALTED;
                    halted_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.load_use            = load_use_s;
    assign bus.en_pc               = en_pc_s;
    assign bus.en_if_id            = en_if_id_s;
    assign bus.en_id_ex            = en_id_ex_s;
    assign bus.flush_if_id         = flush_s;
    assign bus.redirect_regA_ex_dm = a_ex_dm_s;
    assign bus.redirect_regA_dm_wb = a_dm_wb_s;
    assign bus.redirect_regB_ex_dm = b_ex_dm_s;
    assign bus.redirect_regB_dm_wb = b_dm_wb_s;
    assign bus.halted              = halted_r;
    assign bus.stall_cnt           = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed-vector bench for hazard_ctrl_unit with a queue-based scoreboard.
// The driver pushes the hand-computed response; a monitor pops and compares each cycle.
module tb_hazard_ctrl_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    hazard_ctrl_unit_if bus ();

    hazard_ctrl_unit u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [9:0]  exp_ctrl_q [$];
    logic [31:0] exp_cnt_q  [$];
    string       exp_name_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Bit order: load_use, en_pc, en_if_id, en_id_ex, flush, aEX, aWB, bEX, bWB, halted
    function automatic logic [9:0] exp_v(input bit lu, input bit pc, input bit ifid,
                                         input bit idex, input bit fl, input bit aex,
                                         input bit awb, input bit bex, input bit bwb,
                                         input bit h);
        return {lu, pc, ifid, idex, fl, aex, awb, bex, bwb, h};
    endfunction

    task automatic drive(input string nm, input bit rst, input bit ua, input logic [4:0] ra,
                         input bit ub, input logic [4:0] rb, input bit we,
                         input logic [4:0] rw, input bit mtr, input bit jp, input bit halt,
                         input logic [9:0] ectrl, input logic [31:0] ecnt);
        @(posedge clk);
        #1;
        rst_n           = rst;
        bus.id_use_a    = ua;
        bus.id_req_a    = ra;
        bus.id_use_b    = ub;
        bus.id_req_b    = rb;
        bus.id_w_en     = we;
        bus.id_req_w    = rw;
        bus.id_memtoreg = mtr;
        bus.jp_success  = jp;
        bus.halt_req    = halt;
        exp_name_q.push_back(nm);
        exp_ctrl_q.push_back(ectrl);
        exp_cnt_q.push_back(ecnt);
    endtask

    // Monitor: outputs are valid every cycle, sampled mid-cycle on the falling edge.
    initial begin
        logic [9:0]  act_ctrl;
        logic [9:0]  e_ctrl;
        logic [31:0] e_cnt;
        string       nm;
        forever begin
            @(negedge clk);
            if (exp_ctrl_q.size() > 0) begin
                e_ctrl   = exp_ctrl_q.pop_front();
                e_cnt    = exp_cnt_q.pop_front();
                nm       = exp_name_q.pop_front();
                act_ctrl = {bus.load_use, bus.en_pc, bus.en_if_id, bus.en_id_ex,
                            bus.flush_if_id, bus.redirect_regA_ex_dm,
                            bus.redirect_regA_dm_wb, bus.redirect_regB_ex_dm,
                            bus.redirect_regB_dm_wb, bus.halted};
                n_checks++;
                if (act_ctrl !== e_ctrl || bus.stall_cnt !== e_cnt) begin
                    n_fail++;
                    $display("FAIL %s: ctrl=%b stall_cnt=%0d, expected ctrl=%b stall_cnt=%0d",
                             nm, act_ctrl, bus.stall_cnt, e_ctrl, e_cnt);
                end
            end
        end
    end

    initial begin
        logic [9:0] v_norm;
        logic [9:0] v_stall;
        logic [9:0] v_drain;
        logic [9:0] v_halt;
        v_norm  = exp_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v_stall = exp_v(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v_drain = exp_v(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v_halt  = exp_v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        rst_n = 1'b0;
        bus.id_use_a = 1'b0; bus.id_req_a = 5'd0; bus.id_use_b = 1'b0; bus.id_req_b = 5'd0;
        bus.id_w_en = 1'b0; bus.id_req_w = 5'd0; bus.id_memtoreg = 1'b0;
        bus.jp_success = 1'b0; bus.halt_req = 1'b0;

        //    name             rst ua ra     ub rb     we rw     mtr jp halt expected
        drive("reset",         0, 0, 5'd0,  0, 5'd0,  0, 5'd0,  0, 0, 0, v_norm, 32'd0);
        drive("lw8",           1, 1, 5'd29, 0, 5'd0,  1, 5'd8,  1, 0, 0, v_norm, 32'd0);
        drive("lu_stall",      1, 1, 5'd8,  1, 5'd1,  1, 5'd9,  0, 0, 0, v_stall, 32'd0);
        drive("lu_fwd_dmwb",   1, 1, 5'd8,  1, 5'd1,  1, 5'd9,  0, 0, 0,
              exp_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 32'd1);
        drive("add8",          1, 1, 5'd2,  1, 5'd3,  1, 5'd8,  0, 0, 0, v_norm, 32'd1);
        drive("fwd_b_exdm",    1, 1, 5'd2,  1, 5'd8,  1, 5'd10, 0, 0, 0,
              exp_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), 32'd1);
        drive("fwd_b_dmwb",    1, 1, 5'd9,  1, 5'd8,  1, 5'd11, 0, 0, 0,
              exp_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 32'd1);
        drive("fwd_a_exdm",    1, 1, 5'd11, 0, 5'd0,  1, 5'd11, 0, 0, 0,
              exp_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 32'd1);
        drive("nearest_wins",  1, 1, 5'd11, 1, 5'd10, 1, 5'd12, 0, 0, 0,
              exp_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 32'd1);
        drive("lw_r0",         1, 0, 5'd12, 0, 5'd0,  1, 5'd0,  1, 0, 0, v_norm, 32'd1);
        drive("read_r0",       1, 1, 5'd0,  1, 5'd0,  1, 5'd13, 0, 0, 0, v_norm, 32'd1);
        drive("no_use",        1, 0, 5'd13, 0, 5'd13, 1, 5'd14, 1, 0, 0, v_norm, 32'd1);
        drive("jp_over_lu",    1, 1, 5'd14, 0, 5'd0,  1, 5'd14, 0, 1, 0,
              exp_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 32'd1);
        drive("jp_bubble",     1, 1, 5'd14, 0, 5'd0,  0, 5'd0,  0, 0, 0,
              exp_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 32'd1);
        drive("lw5",           1, 0, 5'd0,  0, 5'd0,  1, 5'd5,  1, 0, 0, v_norm, 32'd1);
        drive("lu_b",          1, 0, 5'd0,  1, 5'd5,  0, 5'd0,  0, 0, 0, v_stall, 32'd1);
        drive("halt_jp",       1, 0, 5'd0,  1, 5'd5,  0, 5'd0,  0, 1, 1,
              exp_v(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), 32'd2);
        for (int i = 0; i < 3; i++) begin
            drive("drain",     1, 1, 5'd5,  1, 5'd5,  1, 5'd6,  1, 1, 0, v_drain, 32'd2);
        end
        for (int i = 0; i < 2; i++) begin
            drive("halted",    1, 1, 5'd5,  1, 5'd5,  1, 5'd6,  1, 1, 1, v_halt, 32'd2);
        end
        drive("rst_halted",    0, 0, 5'd0,  0, 5'd0,  0, 5'd0,  0, 0, 0, v_norm, 32'd0);
        drive("run_after_rst", 1, 1, 5'd5,  1, 5'd5,  1, 5'd5,  1, 0, 0, v_norm, 32'd0);
        drive("halt_over_lu",  1, 1, 5'd5,  0, 5'd0,  0, 5'd0,  0, 0, 1, v_norm, 32'd0);
        drive("drain2",        1, 0, 5'd0,  0, 5'd0,  0, 5'd0,  0, 0, 0, v_drain, 32'd0);
        drive("rst_drain",     0, 0, 5'd0,  0, 5'd0,  0, 5'd0,  0, 0, 0, v_norm, 32'd0);
        drive("run_after_rst2",1, 1, 5'd5,  0, 5'd0,  0, 5'd0,  0, 0, 0, v_norm, 32'd0);

        for (int i = 0; i < 10 && exp_ctrl_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_ctrl_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_queue: %0d expected responses left, required 0",
                     exp_ctrl_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
